sparc_fetch_stage: RTL
======================

# sparc_fetch_stage

Instruction-fetch stage of the pipelined SPARC core. Holds the architectural PC/nPC pair, presents the fetch address to the byte-wide instruction ROM, and registers the fetched word into the IF/ID pipeline register. It implements SPARC delayed-branch semantics (target redirect after one delay slot, optional delay-slot annul), load-use stall hold, and fetch/squash counters. It sits directly upstream of decode; `PC_IF` is the value the system bench monitors.

## Interface
- `RESET_PC`, 32'd0: PC value after reset.
- `NOP_WORD`, 32'h0100_0000: word injected into IF/ID on reset or squash (`sethi 0,%g0`).
- `CNT_W`, 16: width of the fetch and squash counters.

- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-low. Sampled low on a rising edge, it resets the stage.
- `stall_F`  in  1: hazard unit hold request for PC, nPC and IF/ID.
- `BR_TAKEN_ID`  in  1: CTI in ID is taken.
- `TA_ID`  in  32: taken target (byte address), valid with `BR_TAKEN_ID`.
- `ANNUL_ID`  in  1: the CTI in ID has its a-bit set.
- `UNCOND_ID`  in  1: the CTI in ID is `ba`/`bn` (a-bit annuls even when taken).
- `B_ID`  in  1: a CTI occupies ID this cycle.
- `IMEM_DATA`  in  32: instruction word from ROM, combinational on `IMEM_ADDR`.
- `IMEM_ADDR`  out  32: equals `PC_IF`.
- `PC_IF`  out  32: current fetch PC.
- `NPC_IF`  out  32: current nPC.
- `INSTR_ID`  out  32: IF/ID instruction.
- `PC_ID`  out  32: IF/ID PC.
- `VALID_ID`  out  1: IF/ID holds a real instruction.
- `FETCH_CNT`  out  CNT_W: instructions latched into IF/ID with `VALID_ID`=1.
- `SQUASH_CNT`  out  CNT_W: delay slots annulled.

## Operation
- The update is evaluated every rising edge. Priority: reset, then `stall_F`, then redirect, then sequential.
- **Reset** (`reset`=0): PC=`RESET_PC`, nPC=`RESET_PC`+4, `INSTR_ID`=`NOP_WORD`, `PC_ID`=0, `VALID_ID`=0, both counters=0.
- **Stall** (`stall_F`=1): PC, nPC, IF/ID and the counters all hold. `B_ID`/`BR_TAKEN_ID` are ignored, because the CTI is still in ID and is re-evaluated when the stall releases.
- **Sequential** (no CTI, or CTI not taken): PC<=nPC, nPC<=nPC+4, `INSTR_ID`<=`IMEM_DATA`, `PC_ID`<=PC, `VALID_ID`<=1.
- **Taken** (`B_ID`&`BR_TAKEN_ID`): the word in IF is the delay slot and is latched normally. PC<=`TA_ID`, nPC<=`TA_ID`+4.
- **Annul rule**: squash=`B_ID`&`ANNUL_ID`&(!`BR_TAKEN_ID` | `UNCOND_ID`).
  - On squash, IF/ID gets `NOP_WORD` with `VALID_ID`=0, and `SQUASH_CNT` increments.
  - PC/nPC update as in the taken or not-taken case.
- `FETCH_CNT` increments on every non-stalled edge that latches `VALID_ID`=1.
- Both counters wrap modulo 2^CNT_W.
- All arithmetic is 32-bit unsigned. nPC+4 wraps at 2^32 without a flag.
- `TA_ID` bits [1:0] are not checked. They are forced to 0 when loaded.

## Timing
- `IMEM_ADDR`/`PC_IF`/`NPC_IF` are registered and change only on rising edges.
- ROM read is combinational, so there is no bubble on sequential flow.
- IF-to-ID latency: 1 cycle.
- Taken branch: the first target fetch occurs in the cycle after the branch leaves ID. The delay slot is the only instruction between them, so there is no extra bubble.
- Stall with redirect in the same cycle: stall wins and the redirect is applied on the first non-stalled edge.
- Reset low mid-stall or mid-redirect: reset wins in that cycle.
- First fetch after reset release is `RESET_PC`, visible at ID one cycle later.

## Configuration
- `SPARC_FETCH_ANNUL_EN` defined: the annul rule above is active.
- Undefined:
  - `ANNUL_ID`/`UNCOND_ID` are ignored.
  - Delay slots always execute.
  - `SQUASH_CNT` is tied to 0.

## Test plan
- Reset held 2 cycles, then released with ROM words 0,4,8 = A,B,C:
  - `PC_IF`=0 during reset.
  - Then `PC_IF` 4, 8, 12 on successive edges.
  - `INSTR_ID`=A,B,C with `PC_ID`=0,4,8 and `VALID_ID`=1.
- `stall_F`=1 for 2 cycles at PC=8: PC stays 8 and `INSTR_ID` holds B for 2 cycles. `FETCH_CNT` does not advance.
- Taken `B_ID` at PC_ID=8, PC_IF=12, `TA_ID`=40, annul off:
  - Next edge: PC=40, `INSTR_ID`=word@12 with `VALID_ID`=1.
  - Following edge: `INSTR_ID`=word@40.
- With the macro defined, untaken conditional branch with `ANNUL_ID`=1 at PC_IF=12:
  - `INSTR_ID`=`NOP_WORD`, `VALID_ID`=0, `SQUASH_CNT`=1.
  - PC continues 16, 20.
- With the macro defined, `ba,a` (`UNCOND_ID`=1, taken, TA=100): delay slot squashed, PC=100 next.
  - Same stimulus without the macro: delay slot valid and `SQUASH_CNT`=0.
- `stall_F`=1 together with `BR_TAKEN_ID`=1, then stall released with the branch still asserted: the redirect to `TA_ID` occurs only on the release edge.
- `reset` low while `BR_TAKEN_ID`=1: PC=`RESET_PC`, `VALID_ID`=0 and both counters 0.

Source files
------------

// File: rtl/sparc_fetch_stage.sv
// SPARC instruction-fetch stage: PC/nPC pair, delayed-branch redirect and the IF/ID register.
// Define SPARC_FETCH_ANNUL_EN to enable delay-slot annulment and the squash counter.
module sparc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] NOP_WORD = 32'h0100_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_F,
  input  logic             BR_TAKEN_ID,
  input  logic [31:0]      TA_ID,
  input  logic             ANNUL_ID,
  input  logic             UNCOND_ID,
  input  logic             B_ID,
  input  logic [31:0]      IMEM_DATA,
  output logic [31:0]      IMEM_ADDR,
  output logic [31:0]      PC_IF,
  output logic [31:0]      NPC_IF,
  output logic [31:0]      INSTR_ID,
  output logic [31:0]      PC_ID,
  output logic             VALID_ID,
  output logic [CNT_W-1:0] FETCH_CNT,
  output logic [CNT_W-1:0] SQUASH_CNT
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      npc_q, npc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_id_q, pc_id_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic             taken;
  logic             squash;
  logic [31:0]      target;

  assign taken  = B_ID & BR_TAKEN_ID;
  // Targets are word aligned; the low address bits from decode are discarded.
  assign target = {TA_ID[31:2], 2'b00};

`ifdef SPARC_FETCH_ANNUL_EN
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
  logic             unused_ta_bits;

  assign squash         = B_ID & ANNUL_ID & (~BR_TAKEN_ID | UNCOND_ID);
  assign unused_ta_bits = ^TA_ID[1:0];
  assign SQUASH_CNT     = squash_cnt_q;
`else
  logic unused_annul_bits;

  assign squash            = 1'b0;
  assign unused_annul_bits = ANNUL_ID ^ UNCOND_ID ^ (^TA_ID[1:0]);
  assign SQUASH_CNT        = '0;
`endif

  // NOTE: every next-state value takes its hold default first so the stalled path
  // cannot leave a variable unassigned and infer a latch.
  always_comb begin
    pc_d        = pc_q;
    npc_d       = npc_q;
    instr_d     = instr_q;
    pc_id_d     = pc_id_q;
    valid_d     = valid_q;
    fetch_cnt_d = fetch_cnt_q;
    if (!stall_F) begin
      if (taken) begin
        pc_d  = target;
        npc_d = target + 32'd4;
      end else begin
        pc_d  = npc_q;
        npc_d = npc_q + 32'd4;
      end
      pc_id_d = pc_q;
      if (squash) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end else begin
        instr_d     = IMEM_DATA;
        valid_d     = 1'b1;
        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef SPARC_FETCH_ANNUL_EN
  always_comb begin
    squash_cnt_d = squash_cnt_q;
    if (!stall_F && squash) squash_cnt_d = squash_cnt_q + CNT_W'(1);
  end
`endif

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      npc_q        <= RESET_PC + 32'd4;
      instr_q      <= NOP_WORD;
      pc_id_q      <= 32'd0;
      valid_q      <= 1'b0;
      fetch_cnt_q  <= '0;
`ifdef SPARC_FETCH_ANNUL_EN
      squash_cnt_q <= '0;
`endif
    end else begin
      pc_q         <= pc_d;
      npc_q        <= npc_d;
      instr_q      <= instr_d;
      pc_id_q      <= pc_id_d;
      valid_q      <= valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
`ifdef SPARC_FETCH_ANNUL_EN
      squash_cnt_q <= squash_cnt_d;
`endif
    end
  end

  assign IMEM_ADDR = pc_q;
  assign PC_IF     = pc_q;
  assign NPC_IF    = npc_q;
  assign INSTR_ID  = instr_q;
  assign PC_ID     = pc_id_q;
  assign VALID_ID  = valid_q;
  assign FETCH_CNT = fetch_cnt_q;

endmodule
